// File: rtl/hack_pkg.sv
// Shared definitions for the Hack writeback stage: word widths, instruction
// field positions, the FSM state type and the jump-condition helper.
package hack_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 15;

  localparam int INSTR_C_BIT = 15;
  localparam int DEST_A      = 5;
  localparam int DEST_D      = 4;
  localparam int DEST_M      = 3;
  localparam int JMP_LT      = 2;
  localparam int JMP_EQ      = 1;
  localparam int JMP_GT      = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    MEM_WR = 1'b1
  } wb_state_t;

  // Jump condition for a C-instruction given the ALU flags.
  function automatic logic jump_taken(input logic [WORD_W-1:0] instr,
                                      input logic zr, input logic ng);
    return (instr[JMP_LT] & ng) |
           (instr[JMP_EQ] & zr) |
           (instr[JMP_GT] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/pc16.sv
// 16-bit program counter: async active-low reset, then load, then increment.
module pc16
  import hack_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [WORD_W-1:0] i_d,
  output logic [WORD_W-1:0] o_q
);

  logic [WORD_W-1:0] r_pc;

  // Load has priority over increment; increment wraps silently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_d;
    end else if (i_inc) begin
      r_pc <= r_pc + 16'd1;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/hack_writeback.sv
// Hack writeback/sequencing stage: commits A/D, resolves jumps into the PC and
// issues data-memory writes over a mem_we/mem_ack handshake.
// Optional feature: define HACK_HALT_DETECT_EN to latch a jump-to-self as
// halted and stop accepting instructions until reset.
//
// state  | meaning
// IDLE   | ready for the next instruction
// MEM_WR | write request held on mem_*, waiting for mem_ack
module hack_writeback
  import hack_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [WORD_W-1:0] a_reg,
  output logic [WORD_W-1:0] d_reg,
  output logic [WORD_W-1:0] pc,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              halted
);

  wb_state_t         r_state;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_d;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_halted;

  logic              w_accept;
  logic              w_is_c;
  logic              w_jump;
  logic [WORD_W-1:0] w_pc;
  logic              w_unused;

  assign w_unused = ^instr[14:6];

  assign w_is_c   = instr[INSTR_C_BIT];
  assign w_jump   = w_is_c & jump_taken(instr, alu_zr, alu_ng);
  assign in_ready = (r_state == IDLE) & ~r_halted;
  assign w_accept = in_valid & in_ready;

  // Jump target is the A value before this instruction's own A update.
  pc16 u_pc (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_accept & w_jump),
    .i_inc   (w_accept & ~w_jump),
    .i_d     (r_a),
    .o_q     (w_pc)
  );

  // Main FSM: register updates at accept, write handshake in MEM_WR.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_d         <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_is_c) begin
              r_a <= instr;
            end else begin
              if (instr[DEST_A]) r_a <= alu_out;
              if (instr[DEST_D]) r_d <= alu_out;
              if (instr[DEST_M]) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_a[ADDR_W-1:0];
                r_mem_wdata <= alu_out;
                r_state     <= MEM_WR;
              end
            end
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            r_mem_we <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef HACK_HALT_DETECT_EN
  // Sticky halt on a taken jump whose target is the current PC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_halted <= 1'b0;
    end else if (w_accept && w_jump && (r_a == w_pc)) begin
      r_halted <= 1'b1;
    end
  end
`else
  assign r_halted = 1'b0;
`endif

  assign a_reg     = r_a;
  assign d_reg     = r_d;
  assign pc        = w_pc;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign halted    = r_halted;

endmodule

// File: tb/tb_hack_writeback.sv
// Scoreboard bench for hack_writeback: stimulus pushes expected register and
// memory-write results, a negedge monitor pops and compares them.
module tb_hack_writeback;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] alu_out = '0;
  logic        alu_zr = 1'b0;
  logic        alu_ng = 1'b0;
  logic [15:0] a_reg, d_reg, pc;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        halted;

  hack_writeback dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .instr     (instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_zr    (alu_zr),
    .alu_ng    (alu_ng),
    .a_reg     (a_reg),
    .d_reg     (d_reg),
    .pc        (pc),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .halted    (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] pc;
    logic        h;
  } exp_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    int          len;
  } mexp_t;

  exp_t  q_exp[$];
  mexp_t q_mem[$];
  int    n_vec = 0;
  int    n_err = 0;

`ifdef HACK_HALT_DETECT_EN
  localparam logic HALT_EXP = 1'b1;
`else
  localparam logic HALT_EXP = 1'b0;
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Present one instruction (called just after a rising edge) and hold it for
  // exactly one accept edge.
  task automatic issue(input logic [15:0] i, input logic [15:0] ao,
                       input logic z, input logic n,
                       input logic [15:0] ea, input logic [15:0] ed,
                       input logic [15:0] epc, input logic eh);
    exp_t e;
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (in_ready !== 1'b1) begin
      fail_now("accept_timeout");
      return;
    end
    e.a = ea; e.d = ed; e.pc = epc; e.h = eh;
    q_exp.push_back(e);
    instr = i; alu_out = ao; alu_zr = z; alu_ng = n;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_mem(input logic [14:0] addr, input logic [15:0] data, input int len);
    mexp_t m;
    m.addr = addr; m.data = data; m.len = len;
    q_mem.push_back(m);
  endtask

  // Ack so that mem_we stays high for len cycles after the accept edge.
  task automatic ack_after(input int len);
    repeat (len - 1) begin
      @(posedge clock); #1;
    end
    mem_ack = 1'b1;
    @(posedge clock); #1;
    mem_ack = 1'b0;
  endtask

  // Monitor: compares committed state after each accept and the write
  // request on every cycle mem_we is high.
  logic p_acc = 1'b0;
  logic p_ack = 1'b0;
  int   wcnt = 0;

  always @(negedge clock) begin
    exp_t  e;
    mexp_t m;
    if (!reset_n) begin
      q_mem.delete();
      wcnt  = 0;
      p_acc = 1'b0;
      p_ack = 1'b0;
    end else begin
      if (p_acc) begin
        if (q_exp.size() == 0) begin
          fail_now("unexpected_accept");
        end else begin
          e = q_exp.pop_front();
          chk("a_reg", a_reg, e.a);
          chk("d_reg", d_reg, e.d);
          chk("pc", pc, e.pc);
          chk("halted", {15'd0, halted}, {15'd0, e.h});
        end
      end
      if (p_ack) begin
        if (q_mem.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          m = q_mem.pop_front();
          chk("mem_we_cycles", wcnt[15:0], m.len[15:0]);
          chk("mem_we_fall", {15'd0, mem_we}, 16'd0);
        end
        wcnt = 0;
      end
      if (mem_we) begin
        wcnt++;
        if (q_mem.size() == 0) begin
          fail_now("unexpected_mem_we");
        end else begin
          chk("mem_addr", {1'b0, mem_addr}, {1'b0, q_mem[0].addr});
          chk("mem_wdata", mem_wdata, q_mem[0].data);
          chk("in_ready_busy", {15'd0, in_ready}, 16'd0);
        end
      end
      p_acc = in_valid & in_ready;
      p_ack = mem_we & mem_ack;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, a_reg, 16'h0000);
    chk({tag, "_d"}, d_reg, 16'h0000);
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_we"}, {15'd0, mem_we}, 16'd0);
    chk({tag, "_addr"}, {1'b0, mem_addr}, 16'h0000);
    chk({tag, "_wdata"}, mem_wdata, 16'h0000);
    chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
    chk({tag, "_ready"}, {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    int t;
    #12;
    chk_zero("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // A-instructions and a D-only C-instruction (mem_ack while idle ignored).
    issue(16'h1234, 16'h0000, 0, 0, 16'h1234, 16'h0000, 16'h0001, 0);
    issue(16'h0010, 16'h0000, 0, 0, 16'h0010, 16'h0000, 16'h0002, 0);
    mem_ack = 1'b1;
    issue(16'hEC10, 16'h0007, 0, 0, 16'h0010, 16'h0007, 16'h0003, 0);
    mem_ack = 1'b0;
    issue(16'h0005, 16'h0000, 0, 0, 16'h0005, 16'h0007, 16'h0004, 0);

    // M|A write, ack delayed; a request during the write must not be taken.
    push_mem(15'h0005, 16'hBEEF, 3);
    issue(16'hE028, 16'hBEEF, 0, 0, 16'hBEEF, 16'h0007, 16'h0005, 0);
    instr = 16'h7777; in_valid = 1'b1;
    ack_after(3);
    in_valid = 1'b0;

    // Jump conditions with A = 0x0040.
    issue(16'h0040, 16'h0000, 0, 0, 16'h0040, 16'h0007, 16'h0006, 0);
    issue(16'hE004, 16'hFFFF, 0, 1, 16'h0040, 16'h0007, 16'h0040, 0);
    issue(16'hE004, 16'h0000, 1, 0, 16'h0040, 16'h0007, 16'h0041, 0);
    issue(16'hE007, 16'h0003, 0, 0, 16'h0040, 16'h0007, 16'h0040, 0);
    issue(16'hE001, 16'h8000, 0, 1, 16'h0040, 16'h0007, 16'h0041, 0);
    issue(16'hE001, 16'h0001, 0, 0, 16'h0040, 16'h0007, 16'h0040, 0);
    issue(16'hE002, 16'h0000, 1, 0, 16'h0040, 16'h0007, 16'h0040, 0);

    // Drive PC to 0xFFFF, then wrap; write at A[14:0] of 0xFFFF.
    issue(16'hE020, 16'hFFFF, 0, 1, 16'hFFFF, 16'h0007, 16'h0041, 0);
    issue(16'hE007, 16'h0000, 1, 0, 16'hFFFF, 16'h0007, 16'hFFFF, 0);
    push_mem(15'h7FFF, 16'h00AA, 2);
    issue(16'hE008, 16'h00AA, 0, 0, 16'hFFFF, 16'h0007, 16'h0000, 0);
    ack_after(2);
    issue(16'h0003, 16'h0000, 0, 0, 16'h0003, 16'h0007, 16'h0001, 0);
    push_mem(15'h0003, 16'h1357, 1);
    issue(16'hE018, 16'h1357, 0, 0, 16'h0003, 16'h1357, 16'h0002, 0);
    ack_after(1);

    // Reset in the middle of a pending write.
    push_mem(15'h0003, 16'h2222, 3);
    issue(16'hE008, 16'h2222, 0, 0, 16'h0003, 16'h1357, 16'h0003, 0);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk_zero("midwr_reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Jump-to-self.
    issue(16'h000A, 16'h0000, 0, 0, 16'h000A, 16'h0000, 16'h0001, 0);
    issue(16'hE007, 16'h0000, 1, 0, 16'h000A, 16'h0000, 16'h000A, 0);
    issue(16'hE007, 16'h0000, 1, 0, 16'h000A, 16'h0000, 16'h000A, HALT_EXP);
`ifdef HACK_HALT_DETECT_EN
    instr = 16'h0001; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("halt_in_ready", {15'd0, in_ready}, 16'd0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
`else
    issue(16'h0001, 16'h0000, 0, 0, 16'h0001, 16'h0000, 16'h000B, 0);
`endif

    t = 0;
    while ((q_exp.size() != 0 || q_mem.size() != 0) && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    if (q_exp.size() != 0) fail_now("exp_queue_not_drained");
    if (q_mem.size() != 0) fail_now("mem_queue_not_drained");
    @(posedge clock); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hack_writeback.md
# hack_writeback

Writeback/sequencing stage directly downstream of the 16-bit ALU in the Hack datapath. It consumes the ALU result (`out`, `zr`, `ng`) together with the instruction that produced it. It updates the A and D registers, evaluates the jump condition, advances or loads the program counter, and issues data-memory writes over a valid/ack handshake. It is the sequential core that closes the loop between instruction fetch and the combinational ALU.

## Interface
- No parameters; width fixed at 16 bits.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr`  in  16  Hack instruction paired with the current ALU result.
- `in_valid`  in  1  `instr` and ALU inputs are valid.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `alu_out`  in  16  ALU result.
- `alu_zr`  in  1  ALU zero flag.
- `alu_ng`  in  1  ALU negative flag.
- `a_reg`  out  16  A register; also drives the ALU y/M mux upstream.
- `d_reg`  out  16  D register.
- `pc`  out  16  address of the next instruction to fetch.
- `mem_we`  out  1  data-memory write request.
- `mem_addr`  out  15  write address.
- `mem_wdata`  out  16  write data.
- `mem_ack`  in  1  memory accepted the write.
- `halted`  out  1  jump-to-self detected (see Configuration).

## Operation
- Accept condition: `in_valid & in_ready` at a rising edge.
- A-instruction (`instr[15]=0`): A <= `instr`; PC <= PC+1 (mod 2^16). D and memory are untouched.
- C-instruction (`instr[15]=1`):
  - Destinations: `instr[5]` A <= `alu_out`; `instr[4]` D <= `alu_out`; `instr[3]` memory write of `alu_out` at the pre-update A[14:0].
  - Jump taken = (`instr[2]` & ng) | (`instr[1]` & zr) | (`instr[0]` & ~ng & ~zr).
  - If the jump is taken, PC <= the pre-update A. Otherwise PC <= PC+1.
  - A/D/PC updates all commit at the accept edge.
- FSM:
  - `IDLE`: `in_ready`=1. Accepting a C-instruction with `instr[3]`=1 moves to `MEM_WR`. Any other accept stays in `IDLE`.
  - `MEM_WR`: `mem_we`=1 with `mem_addr`/`mem_wdata` held stable; `in_ready`=0. On `mem_ack`, return to `IDLE`; `mem_we` falls on the same edge.
- All state-holding outputs are registered. `in_ready` is decoded from the state.
- Reset: A=0, D=0, PC=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `halted`=0, state `IDLE`. Reset during `MEM_WR` abandons the write immediately, asynchronously.
- PC wraps from 0xFFFF to 0x0000. The wrap is not flagged.

## Timing
- Latency: one cycle from accept to updated `a_reg`/`d_reg`/`pc`/`mem_we`.
- Throughput: one instruction per cycle when no memory write is pending. A write costs at least 2 cycles; `mem_ack` is sampled no earlier than the cycle after `mem_we` rises.
- `mem_ack` while `mem_we`=0 is ignored.
- `in_valid` without `in_ready` causes no state change. Upstream must hold `instr`/ALU inputs stable until accepted.

## Configuration
- `HACK_HALT_DETECT_EN` defined:
  - An accepted C-instruction with a taken jump whose target equals the current `pc` sets `halted`=1.
  - The stage then holds `in_ready`=0 permanently until reset. A pending memory write still completes.
- Not defined: `halted` is tied to 0, and jump-to-self loops run normally.

## Structure
- Shared package `hack_pkg`:
  - Instruction field positions (`INSTR_C_BIT`, `DEST_A/D/M`, `JMP_LT/EQ/GT`).
  - Word width constant.
  - FSM state typedef (`IDLE`, `MEM_WR`).
- Sub-module `pc16`: 16-bit program counter with priority reset > load > inc, and async active-low reset.

## Test plan
- Reset, then A-instr 0x1234 accepted → `a_reg`=0x1234 and `pc`=1 one cycle later; `d_reg`=0.
- A=0x0010, C-instr dest=D (`instr`=0xEC10 with `alu_out`=0x0007) → `d_reg`=7, A unchanged, `pc`+1.
- A=0x0005, C-instr dest=M|A, `alu_out`=0xBEEF, `mem_ack` delayed 3 cycles:
  - `mem_we`=1, `mem_addr`=5, `mem_wdata`=0xBEEF for 3 cycles, `in_ready`=0 throughout.
  - `a_reg`=0xBEEF.
  - `IDLE` resumes after ack.
- A=0x0040 with JLT, `alu_ng`=1 → `pc`=0x0040. Same instruction with `alu_zr`=1 → `pc`+1. JMP (all jump bits set) → 0x0040 unconditionally.
- `pc`=0xFFFF with an A-instr → `pc`=0x0000. Assert `reset_n`=0 mid-`MEM_WR` → `mem_we` drops immediately and all outputs read 0.
- With `HACK_HALT_DETECT_EN`: `pc`=0x000A, A=0x000A, `0;JMP` → `halted`=1, `in_ready`=0 persists. Without the macro, `halted` stays 0 and `pc` stays at 0x000A.
